// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// IFU_MISALIGN_TRAP_EN enables the misaligned-target fault path in the users of this package.
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } ifu_state_e;

  localparam logic [1:0]  BR_NONE = 2'b00;
  localparam logic [1:0]  BR_ZERO = 2'b01;
  localparam logic [1:0]  BR_SIGN = 2'b10;
  localparam logic [1:0]  BR_JAL  = 2'b11;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

  function automatic logic br_cond_met(input logic [1:0] br_type,
                                       input logic       zero_flag,
                                       input logic       sign_flag);
    case (br_type)
      BR_NONE: br_cond_met = 1'b0;
      BR_ZERO: br_cond_met = zero_flag;
      BR_SIGN: br_cond_met = sign_flag;
      BR_JAL:  br_cond_met = 1'b1;
      default: br_cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch decision: taken flag and effective redirect target.
// With IFU_MISALIGN_TRAP_EN the raw target is passed through and flagged if misaligned; otherwise it is word-aligned.
module branch_resolve
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic              zero_flag,
  input  logic              sign_flag,
  input  logic [ADDR_W-1:0] br_target,
  output logic              taken,
  output logic [ADDR_W-1:0] target
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(2'b11);

  // Resolve the decoder branch code against the ALU flags.
  always_comb begin
    taken  = br_valid && br_cond_met(br_type, zero_flag, sign_flag);
`ifdef IFU_MISALIGN_TRAP_EN
    target     = br_target;
    misaligned = ((br_target & ALIGN_MASK) != {ADDR_W{1'b0}});
`else
    target     = br_target & ~ALIGN_MASK;
`endif
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding instruction-memory reads, decoder handoff and branch redirect.
// Define IFU_MISALIGN_TRAP_EN to trap taken branches to non-word-aligned targets (sticky fetch_fault).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic              zero_flag,
  input  logic              sign_flag,
  input  logic [ADDR_W-1:0] br_target,
  output logic              fetch_fault
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  ifu_state_e        state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [ADDR_W-1:0] instr_pc_r;
  logic [ADDR_W-1:0] pc_plus4_r;
  logic [DATA_W-1:0] instr_r;
  logic              req_valid_r;
  logic              instr_valid_r;
  logic              drop_r;
  logic              taken_s;
  logic [ADDR_W-1:0] target_s;
`ifdef IFU_MISALIGN_TRAP_EN
  logic              misaligned_s;
  logic              fault_r;
`endif

  branch_resolve #(.ADDR_W(ADDR_W)) u_branch_resolve (
    .br_valid   (br_valid),
    .br_type    (br_type),
    .zero_flag  (zero_flag),
    .sign_flag  (sign_flag),
    .br_target  (br_target),
    .taken      (taken_s),
    .target     (target_s)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .misaligned (misaligned_s)
`endif
  );

  // Fetch FSM; req_addr_r stays frozen while a request waits, pc_r tracks redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      req_addr_r    <= RESET_PC;
      req_valid_r   <= 1'b0;
      instr_r       <= {DATA_W{1'b0}};
      instr_pc_r    <= RESET_PC;
      pc_plus4_r    <= RESET_PC + PC_STEP;
      instr_valid_r <= 1'b0;
      drop_r        <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_r       <= 1'b0;
    end else if (taken_s && misaligned_s) begin
      fault_r       <= 1'b1;
      state_r       <= ST_FAULT;
      req_valid_r   <= 1'b0;
      instr_valid_r <= 1'b0;
      drop_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r     <= ST_REQ;
          req_valid_r <= 1'b1;
          if (taken_s) begin
            pc_r       <= target_s;
            req_addr_r <= target_s;
          end else begin
            req_addr_r <= pc_r;
          end
        end
        ST_REQ: begin
          // A redirect cannot retract a presented request; mark its response for discard.
          if (taken_s) begin
            pc_r   <= target_s;
            drop_r <= 1'b1;
          end
          if (imem_req_ready) begin
            state_r     <= ST_WAIT;
            req_valid_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (taken_s || drop_r) begin
              state_r     <= ST_REQ;
              req_valid_r <= 1'b1;
              drop_r      <= 1'b0;
              if (taken_s) begin
                pc_r       <= target_s;
                req_addr_r <= target_s;
              end else begin
                req_addr_r <= pc_r;
              end
            end else begin
              instr_r       <= imem_rsp_data;
              instr_pc_r    <= pc_r;
              pc_plus4_r    <= pc_r + PC_STEP;
              instr_valid_r <= 1'b1;
              state_r       <= ST_HOLD;
            end
          end else if (taken_s) begin
            pc_r   <= target_s;
            drop_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          // Redirect wins over a simultaneous decoder accept.
          if (taken_s) begin
            pc_r          <= target_s;
            req_addr_r    <= target_s;
            instr_valid_r <= 1'b0;
            req_valid_r   <= 1'b1;
            state_r       <= ST_REQ;
          end else if (instr_ready) begin
            pc_r          <= pc_r + PC_STEP;
            req_addr_r    <= pc_r + PC_STEP;
            instr_valid_r <= 1'b0;
            req_valid_r   <= 1'b1;
            state_r       <= ST_REQ;
          end
        end
        ST_FAULT: begin
          req_valid_r   <= 1'b0;
          instr_valid_r <= 1'b0;
        end
        default: begin
          state_r       <= ST_IDLE;
          req_valid_r   <= 1'b0;
          instr_valid_r <= 1'b0;
          drop_r        <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = req_addr_r;
  assign instr_valid    = instr_valid_r;
  assign instr          = instr_r;
  assign instr_pc       = instr_pc_r;
  assign pc_plus4       = pc_plus4_r;
`ifdef IFU_MISALIGN_TRAP_EN
  assign fetch_fault    = fault_r;
`else
  assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; memory returns 0x0400_0000 ^ address.
// Fault-trap expectations follow IFU_MISALIGN_TRAP_EN.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        br_valid;
  logic [1:0]  br_type;
  logic        zero_flag;
  logic        sign_flag;
  logic [31:0] br_target;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .br_valid(br_valid), .br_type(br_type), .zero_flag(zero_flag), .sign_flag(sign_flag),
    .br_target(br_target), .fetch_fault(fetch_fault)
  );

  initial forever #5 clk = ~clk;

  // Memory model: latches an accepted request, answers mem_lat cycles later for one cycle.
  initial begin : mem_model
    logic        acc;
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      acc = imem_req_valid && imem_req_ready && !rst;
      a   = imem_addr;
      if (acc) begin
        for (int i = 1; i < mem_lat; i++) @(posedge clk);
      end
      @(negedge clk);
      imem_rsp_valid = acc && !rst;
      imem_rsp_data  = acc ? (32'h0400_0000 ^ a) : 32'h0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_req(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (imem_req_valid === level) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_instr(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic br_pulse(input logic [1:0] t, input logic z, input logic s, input logic [31:0] tgt);
    br_valid = 1'b1; br_type = t; zero_flag = z; sign_flag = s; br_target = tgt;
    @(negedge clk);
    br_valid = 1'b0; br_type = 2'b00; zero_flag = 1'b0; sign_flag = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b0;
    br_valid = 1'b0; br_type = 2'b00; zero_flag = 1'b0; sign_flag = 1'b0; br_target = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
    n_checks++; if (pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc_plus4: got %h want 4", pc_plus4); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_first_fetch;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ff_wait_req: got %b want 0", imem_req_valid); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ff_wait_valid: got %b want 0", instr_valid); end
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL ff_valid: got %b want 1", instr_valid); end
    n_checks++; if (instr !== 32'h0400_0000) begin n_fail++; $display("FAIL ff_instr: got %h want 04000000", instr); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL ff_instr_pc: got %h want 0", instr_pc); end
    n_checks++; if (pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL ff_pc_plus4: got %h want 4", pc_plus4); end
  endtask

  task automatic test_decoder_stall;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (instr !== 32'h0400_0000) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want 04000000", i, instr); end
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req_valid); end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL accept_req_valid: got %b want 1", imem_req_valid); end
    n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL accept_addr: got %h want 4", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL accept_valid: got %b want 0", instr_valid); end
  endtask

  task automatic test_throughput;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL tp_valid: got %b want 1", instr_valid); end
    n_checks++; if (instr !== 32'h0400_0004) begin n_fail++; $display("FAIL tp_instr: got %h want 04000004", instr); end
    n_checks++; if (instr_pc !== 32'h4) begin n_fail++; $display("FAIL tp_instr_pc: got %h want 4", instr_pc); end
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL tp_req_valid: got %b want 1", imem_req_valid); end
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL tp_addr: got %h want 8", imem_addr); end
  endtask

  task automatic test_branch_wait;
    bit ok;
    instr_ready = 1'b0;
    mem_lat = 3;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bw_in_wait: got %b want 0", imem_req_valid); end
    br_pulse(2'b11, 1'b0, 1'b0, 32'h40);
    wait_req(1'b1, 12, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bw_req_timeout: got no request want request"); end
    n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL bw_addr: got %h want 40", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL bw_stale_valid: got %b want 0", instr_valid); end
    wait_instr(12, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bw_instr_timeout: got no instr want instr"); end
    n_checks++; if (instr !== 32'h0400_0040) begin n_fail++; $display("FAIL bw_instr: got %h want 04000040", instr); end
    n_checks++; if (instr_pc !== 32'h40) begin n_fail++; $display("FAIL bw_instr_pc: got %h want 40", instr_pc); end
    n_checks++; if (pc_plus4 !== 32'h44) begin n_fail++; $display("FAIL bw_pc_plus4: got %h want 44", pc_plus4); end
    mem_lat = 1;
  endtask

  task automatic test_cond_branch;
    bit ok;
    br_pulse(2'b01, 1'b0, 1'b1, 32'h100);
    n_checks++; if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL cb_zero_nt: got valid=%b req=%b want 1/0", instr_valid, imem_req_valid); end
    br_pulse(2'b10, 1'b1, 1'b0, 32'h100);
    n_checks++; if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL cb_sign_nt: got valid=%b req=%b want 1/0", instr_valid, imem_req_valid); end
    br_pulse(2'b00, 1'b1, 1'b1, 32'h100);
    n_checks++; if (instr_pc !== 32'h40 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL cb_none: got pc=%h req=%b want 40/0", instr_pc, imem_req_valid); end
    instr_ready = 1'b1;
    br_pulse(2'b01, 1'b1, 1'b0, 32'h100);
    instr_ready = 1'b0;
    n_checks++; if (imem_addr !== 32'h100 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL cb_zero_taken: got addr=%h req=%b want 100/1", imem_addr, imem_req_valid); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL cb_taken_valid: got %b want 0", instr_valid); end
    wait_instr(10, ok);
    n_checks++; if (!ok || instr !== 32'h0400_0100) begin n_fail++; $display("FAIL cb_instr: got %h want 04000100", instr); end
    br_pulse(2'b10, 1'b0, 1'b1, 32'h180);
    n_checks++; if (imem_addr !== 32'h180 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL cb_sign_taken: got addr=%h req=%b want 180/1", imem_addr, imem_req_valid); end
    wait_instr(10, ok);
    n_checks++; if (!ok || instr_pc !== 32'h180) begin n_fail++; $display("FAIL cb_sign_pc: got %h want 180", instr_pc); end
  endtask

  task automatic test_redirect_with_rsp;
    bit ok;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if (imem_addr !== 32'h184) begin n_fail++; $display("FAIL rr_seq_addr: got %h want 184", imem_addr); end
    @(negedge clk);
    br_pulse(2'b11, 1'b0, 1'b0, 32'h200);
    n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rr_req: got req=%b addr=%h want 1/200", imem_req_valid, imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rr_discard: got %b want 0", instr_valid); end
    wait_instr(10, ok);
    n_checks++; if (!ok || instr !== 32'h0400_0200) begin n_fail++; $display("FAIL rr_instr: got %h want 04000200", instr); end
  endtask

  task automatic test_redirect_unaccepted;
    bit ok;
    imem_req_ready = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if (imem_addr !== 32'h204 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL ru_req: got addr=%h req=%b want 204/1", imem_addr, imem_req_valid); end
    br_pulse(2'b11, 1'b0, 1'b0, 32'h2F0);
    n_checks++; if (imem_addr !== 32'h204 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL ru_stable1: got addr=%h req=%b want 204/1", imem_addr, imem_req_valid); end
    br_pulse(2'b11, 1'b0, 1'b0, 32'h300);
    n_checks++; if (imem_addr !== 32'h204) begin n_fail++; $display("FAIL ru_stable2: got %h want 204", imem_addr); end
    imem_req_ready = 1'b1;
    wait_req(1'b0, 10, ok);
    wait_req(1'b1, 10, ok);
    n_checks++; if (!ok || imem_addr !== 32'h300) begin n_fail++; $display("FAIL ru_last_target: got %h want 300", imem_addr); end
    wait_instr(10, ok);
    n_checks++; if (!ok || instr !== 32'h0400_0300) begin n_fail++; $display("FAIL ru_instr: got %h want 04000300", instr); end
  endtask

  task automatic test_wrap;
    bit ok;
    br_pulse(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFC);
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_addr: got %h want fffffffc", imem_addr); end
    wait_instr(10, ok);
    n_checks++; if (!ok || instr_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_instr_pc: got %h want fffffffc", instr_pc); end
    n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wr_pc_plus4: got %h want 0", pc_plus4); end
    n_checks++; if (instr !== 32'hFBFF_FFFC) begin n_fail++; $display("FAIL wr_instr: got %h want fbfffffc", instr); end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++; if (imem_addr !== 32'h0 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL wr_next: got addr=%h req=%b want 0/1", imem_addr, imem_req_valid); end
    wait_instr(10, ok);
    n_checks++; if (!ok || instr_pc !== 32'h0) begin n_fail++; $display("FAIL wr_pc0: got %h want 0", instr_pc); end
  endtask

  task automatic test_misalign;
`ifdef IFU_MISALIGN_TRAP_EN
    br_pulse(2'b11, 1'b0, 1'b0, 32'h42);
    n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL ma_fault: got %b want 1", fetch_fault); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ma_valid: got %b want 0", instr_valid); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (imem_req_valid !== 1'b0 || fetch_fault !== 1'b1) begin n_fail++; $display("FAIL ma_hold[%0d]: got req=%b fault=%b want 0/1", i, imem_req_valid, fetch_fault); end
      @(negedge clk);
    end
`else
    bit ok;
    br_pulse(2'b11, 1'b0, 1'b0, 32'h42);
    n_checks++; if (imem_addr !== 32'h40 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL ma_align: got addr=%h req=%b want 40/1", imem_addr, imem_req_valid); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL ma_nofault: got %b want 0", fetch_fault); end
    wait_instr(10, ok);
    n_checks++; if (!ok || instr_pc !== 32'h40) begin n_fail++; $display("FAIL ma_instr_pc: got %h want 40", instr_pc); end
`endif
  endtask

  task automatic test_reset_midop;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL mr_instr: got valid=%b instr=%h want 0/0", instr_valid, instr); end
    n_checks++; if (imem_req_valid !== 1'b0 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL mr_req_fault: got req=%b fault=%b want 0/0", imem_req_valid, fetch_fault); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mr_restart: got req=%b addr=%h want 1/0", imem_req_valid, imem_addr); end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_decoder_stall;
    test_throughput;
    test_branch_wait;
    test_cond_branch;
    test_redirect_with_rsp;
    test_redirect_unaccepted;
    test_wrap;
    test_misalign;
    test_reset_midop;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
